ocm_stream_reader: RTL and testbench

- Avalon-MM read master for the 64-bit second port (s2) of the dual-port on-chip probability memory.
- On a start command it fetches a contiguous run of 64-bit words, wrapping at the end of the memory.
- The words are presented as a valid/ready stream with a last-word marker, feeding the SERDES channel/noise datapath.
- A small internal FIFO with read-credit accounting absorbs back-pressure, because the memory port has no wait-request.

---
 rtl/ocm_pkg.sv | 26 ++
 rtl/ocm_sync_fifo.sv | 75 +++++++
 rtl/ocm_stream_reader.sv | 201 ++++++++++++++++++++
 tb/tb_ocm_stream_reader.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ocm_pkg.sv
// -----------------------------------------------------------------------------
// ocm_pkg
// Shared constants and types for the on-chip probability memory (OCM) and the
// blocks that read it over its 64-bit second port.
//   OCM_ADDR_W      word address width of the memory port
//   OCM_DATA_W      data width of the memory port
//   OCM_WORDS       number of words on the port (address wrap point)
//   OCM_RD_LATENCY  cycles from chipselect to valid readdata
//   OCM_LEN_W       width of run-length counters
//   ocm_state_e     reader control states
// -----------------------------------------------------------------------------
package ocm_pkg;

  localparam int OCM_ADDR_W     = 14;
  localparam int OCM_DATA_W     = 64;
  localparam int OCM_WORDS      = 8960;
  localparam int OCM_RD_LATENCY = 1;
  localparam int OCM_LEN_W      = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ocm_state_e;

endpackage

// File: rtl/ocm_sync_fifo.sv
// -----------------------------------------------------------------------------
// ocm_sync_fifo
// Single-clock FIFO used as the stream output buffer. Show-ahead: rdata is the
// head entry whenever empty is low. Flush has priority over push and pop.
// Push while full is accepted only when a pop happens in the same cycle.
//   clk, rst_n     clock, asynchronous active-low reset
//   push, wdata    write request and data
//   pop            remove head entry (ignored when empty)
//   flush          discard all entries
//   rdata          head entry
//   full, empty    occupancy flags
//   count          number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module ocm_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full      = (r_count == (AW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || pop);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; entries are only ever
  // observed through the pointers/count, which are reset, so a reset here
  // would only cost a wide reset network.
  always_ff @(posedge clk) begin
    if (w_push_ok && !flush) r_mem[r_wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ocm_stream_reader.sv
// -----------------------------------------------------------------------------
// ocm_stream_reader
// Avalon-MM read master for the 64-bit port of the on-chip probability memory.
// A start command fetches num_words consecutive words from base_addr (wrapping
// at MEM_WORDS) and presents them as a valid/ready stream with a last marker.
// The memory port has no wait-request, so reads are only issued when the
// output FIFO has room for them (FIFO entries + reads in flight < FIFO_DEPTH).
//   clk, reset_n         clock, asynchronous active-low reset
//   start, base_addr,
//   num_words            run command (start sampled only when idle)
//   abort                cancel the current run (no done pulse)
//   busy, done           run in progress / one-cycle completion pulse
//   mem_*                Avalon-MM port to the memory (address2, chipselect2..)
//   out_data, out_valid,
//   out_last, out_ready  output stream
// -----------------------------------------------------------------------------
module ocm_stream_reader
  import ocm_pkg::*;
#(
  parameter int ADDR_W     = OCM_ADDR_W,
  parameter int DATA_W     = OCM_DATA_W,
  parameter int MEM_WORDS  = OCM_WORDS,
  parameter int LEN_W      = OCM_LEN_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [LEN_W-1:0]    num_words,
  output logic                busy,
  output logic                done,
  input  logic                abort,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  output logic                out_last,
  input  logic                out_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;

  ocm_state_e                r_state;
  ocm_state_e                w_state_nxt;
  logic [ADDR_W-1:0]         r_addr;
  logic [LEN_W-1:0]          r_issue_cnt;
  logic [LEN_W-1:0]          r_rcv_cnt;
  logic [LEN_W-1:0]          r_pop_cnt;   // words still to be handed downstream
  logic [OCM_RD_LATENCY-1:0] r_rd_pipe;   // one bit per read still in flight
  logic                      r_done;

  logic [ADDR_W-1:0] w_addr_inc;
  logic [DATA_W-1:0] w_rdata;
  logic [CNT_W-1:0]  w_count;
  logic [OCC_W-1:0]  w_occ;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_hs;
  logic              w_last_hs;
  logic              w_abort;
  logic              w_issue;
  logic              w_run_start;
  logic              w_zero_start;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  assign w_run_start  = (r_state == IDLE) && start && (num_words != '0);
  assign w_zero_start = (r_state == IDLE) && start && (num_words == '0);
  assign w_abort      = abort && (r_state != IDLE);
  assign w_push       = r_rd_pipe[OCM_RD_LATENCY-1];
  assign w_hs         = !w_empty && out_ready;
  assign w_last_hs    = w_hs && (r_pop_cnt == LEN_W'(1));

  // Space reservation: a read is only issued if its data is guaranteed a slot,
  // counting reads already on their way back from the memory.
  assign w_occ   = OCC_W'(w_count) + OCC_W'($countones(r_rd_pipe));
  assign w_issue = (r_state == RUN) && (r_issue_cnt != '0) && !abort &&
                   !w_full && (w_occ < OCC_W'(FIFO_DEPTH));

  // Address arithmetic is modulo MEM_WORDS, not 2^ADDR_W.
  assign w_addr_inc = (r_addr == ADDR_W'(MEM_WORDS - 1)) ? '0 : r_addr + ADDR_W'(1);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case statement
  // so no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_run_start) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_abort)                                  w_state_nxt = IDLE;
        else if (w_issue && r_issue_cnt == LEN_W'(1)) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        // Leaving on the final handshake lets busy fall in the done cycle.
        if (w_abort) w_state_nxt = IDLE;
        else if (w_last_hs || (w_empty && r_rcv_cnt == '0 && r_rd_pipe == '0))
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy           = (r_state != IDLE);
    mem_chipselect = w_issue;
    done           = r_done;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr      <= '0;
      r_issue_cnt <= '0;
      r_rcv_cnt   <= '0;
      r_pop_cnt   <= '0;
      r_rd_pipe   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_zero_start || (w_last_hs && !w_abort);
      // Shift register of outstanding reads; abort drops the one in flight.
      r_rd_pipe <= w_abort ? '0 : OCM_RD_LATENCY'({r_rd_pipe, w_issue});
      if (w_run_start) begin
        r_addr      <= base_addr;
        r_issue_cnt <= num_words;
        r_rcv_cnt   <= num_words;
        r_pop_cnt   <= num_words;
      end else if (w_abort) begin
        r_issue_cnt <= '0;
        r_rcv_cnt   <= '0;
        r_pop_cnt   <= '0;
      end else begin
        if (w_issue) begin
          r_addr      <= w_addr_inc;
          r_issue_cnt <= r_issue_cnt - LEN_W'(1);
        end
        if (w_push) r_rcv_cnt <= r_rcv_cnt - LEN_W'(1);
        if (w_hs)   r_pop_cnt <= r_pop_cnt - LEN_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output buffer; abort flushes it, which also discards a read landing now.
  // ---------------------------------------------------------------------------
  ocm_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_out_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (w_push),
    .wdata (mem_readdata),
    .pop   (w_hs),
    .flush (w_abort),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // ---------------------------------------------------------------------------
  // Static memory-port controls and stream outputs
  // ---------------------------------------------------------------------------
  assign mem_address    = r_addr;
  assign mem_write      = 1'b0;
  assign mem_byteenable = '1;
  assign mem_clken      = 1'b1;

  // Head data is masked while empty so stale or uninitialised entries never
  // reach the stream pins.
  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : w_rdata;
  assign out_last  = !w_empty && (r_pop_cnt == LEN_W'(1));

endmodule

// File: tb/tb_ocm_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_ocm_stream_reader
// Directed bench for ocm_stream_reader. A behavioural model of the memory port
// returns a known word per address one cycle after chipselect. A single test
// thread drives inputs just after the rising edge and samples outputs on the
// falling edge, checking addresses, data, last marker, hold-while-stalled and
// outstanding-read bounds on every cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ocm_stream_reader;

  localparam int MEMW = 8960;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [13:0] base_addr;
  logic [14:0] num_words;
  logic        busy;
  logic        done;
  logic        abort;
  logic [13:0] mem_address;
  logic        mem_chipselect;
  logic        mem_write;
  logic [7:0]  mem_byteenable;
  logic        mem_clken;
  logic [63:0] mem_readdata = '0;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;

  ocm_stream_reader dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .num_words      (num_words),
    .busy           (busy),
    .done           (done),
    .abort          (abort),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_byteenable (mem_byteenable),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_last       (out_last),
    .out_ready      (out_ready)
  );

  always #5 clk = ~clk;

  // Known content per address.
  function automatic logic [63:0] word_of(input int a);
    int b;
    b = a;
    return {16'hC0DE, b[15:0], ~b[15:0], 16'hBEEF};
  endfunction

  function automatic int exp_addr(input int base, input int idx);
    return (base + idx) % MEMW;
  endfunction

  // Memory port model: latency 1, poison value when not selected.
  always @(posedge clk) begin
    if (mem_chipselect) mem_readdata <= word_of(int'(mem_address));
    else                mem_readdata <= 64'hDEAD_DEAD_DEAD_DEAD;
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Running totals maintained by the sampler, and per-run snapshots.
  int          cs_total = 0, pops_total = 0, done_total = 0, busy_total = 0;
  int          cs_base = 0, pop_base = 0, done_base = 0, busy_base = 0;
  int          run_base = 0, run_n = 0;
  logic        prev_stall = 1'b0, prev_abort = 1'b0;
  logic [63:0] prev_data = '0;
  logic [4:0]  last_snap;   // {chipselect, valid, last, done, busy}

  task automatic sample();
    int idx;
    last_snap = {mem_chipselect, out_valid, out_last, done, busy};
    if (mem_chipselect) begin
      idx = cs_total - cs_base;
      check("addr", 64'(mem_address), 64'(exp_addr(run_base, idx)));
      check("outstanding_le_4",
            64'(((cs_total + 1 - cs_base) - (pops_total - pop_base)) <= 4), 64'd1);
      cs_total++;
    end
    if (out_valid && out_ready) begin
      idx = pops_total - pop_base;
      check("data", out_data, word_of(exp_addr(run_base, idx)));
      check("last", 64'(out_last), 64'(idx == run_n - 1));
      pops_total++;
    end
    if (prev_stall && !prev_abort && reset_n) begin
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_data", out_data, prev_data);
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_abort = abort;
    if (done) done_total++;
    if (busy) busy_total++;
  endtask

  // One clock: sample on the falling edge, return just after the rising edge.
  task automatic cycle();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  // Drives the start strobe for one cycle; returns in the first cycle after it.
  task automatic begin_run(input int base, input int n);
    run_base  = base;
    run_n     = n;
    cs_base   = cs_total;
    pop_base  = pops_total;
    done_base = done_total;
    busy_base = busy_total;
    base_addr = 14'(base);
    num_words = 15'(n);
    start     = 1'b1;
    cycle();
    start     = 1'b0;
  endtask

  // Waits (bounded) for done, then checks the run totals.
  task automatic finish_run(input string tag, input int n, input int max_cyc);
    int k;
    k = 0;
    while (done_total == done_base && k < max_cyc) begin
      cycle();
      k++;
    end
    cycle();
    cycle();
    check({tag, "_done_count"}, 64'(done_total - done_base), 64'd1);
    check({tag, "_words"},      64'(pops_total - pop_base),  64'(n));
    check({tag, "_reads"},      64'(cs_total - cs_base),     64'(n));
  endtask

  // Per-cycle expectation for base 0x10, 5 words, ready high (cycles 1..9).
  logic [4:0] tbl_t1 [1:9];

  initial begin
    int k;
    int cs_hold;
    tbl_t1 = '{5'b10001, 5'b10001, 5'b11001, 5'b11001, 5'b11001,
               5'b01001, 5'b01101, 5'b00010, 5'b00000};

    reset_n   = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    base_addr = '0;
    num_words = '0;
    out_ready = 1'b0;
    cycle();
    cycle();

    // Reset values.
    check("rst_ctrl_outputs", 64'(last_snap), 64'd0);
    check("rst_address",      64'(mem_address), 64'd0);
    check("rst_out_data",     out_data, 64'd0);
    check("rst_byteenable",   64'(mem_byteenable), 64'hFF);
    check("rst_clken",        64'(mem_clken), 64'd1);
    check("rst_write",        64'(mem_write), 64'd0);
    reset_n = 1'b1;
    cycle();

    // Basic run with exact per-cycle timing.
    out_ready = 1'b1;
    begin_run(16'h0010, 5);
    for (int c = 1; c <= 9; c++) begin
      cycle();
      check($sformatf("t1_cycle%0d", c), 64'(last_snap), 64'(tbl_t1[c]));
    end
    check("t1_busy_cycles", 64'(busy_total - busy_base), 64'd7);
    finish_run("t1", 5, 20);

    // Wrap at the top of memory.
    begin_run(8958, 4);
    finish_run("wrap", 4, 40);

    // Back-pressure: at most four reads while stalled, nothing lost.
    out_ready = 1'b0;
    begin_run(16'h0300, 12);
    repeat (20) cycle();
    check("stall_reads",   64'(cs_total - cs_base), 64'd4);
    check("stall_valid",   64'(out_valid), 64'd1);
    check("stall_no_done", 64'(done_total - done_base), 64'd0);
    out_ready = 1'b1;
    finish_run("stall", 12, 100);

    // Random ready at 50 %.
    begin_run(16'h1000, 100);
    k = 0;
    while (done_total == done_base && k < 3000) begin
      out_ready = 1'($urandom_range(0, 1));
      cycle();
      k++;
    end
    out_ready = 1'b1;
    finish_run("random", 100, 10);

    // Zero-length run.
    begin_run(16'h0040, 0);
    cycle();
    check("zero_cycle1", 64'(last_snap), 64'(5'b00010));
    cycle();
    check("zero_cycle2", 64'(last_snap), 64'd0);
    check("zero_done_count", 64'(done_total - done_base), 64'd1);
    check("zero_reads", 64'(cs_total - cs_base), 64'd0);
    check("zero_busy",  64'(busy_total - busy_base), 64'd0);

    // Abort after three words of ten.
    begin_run(16'h0200, 10);
    k = 0;
    while ((pops_total - pop_base) < 3 && k < 40) begin
      cycle();
      k++;
    end
    check("abort_three_words", 64'(pops_total - pop_base), 64'd3);
    abort     = 1'b1;
    out_ready = 1'b0;
    cycle();
    abort = 1'b0;
    cycle();
    check("abort_next_cycle", 64'(last_snap), 64'd0);
    cs_hold = cs_total;
    repeat (10) cycle();
    check("abort_no_reads", 64'(cs_total - cs_hold), 64'd0);
    check("abort_no_done",  64'(done_total - done_base), 64'd0);
    out_ready = 1'b1;
    begin_run(16'h0020, 2);
    finish_run("post_abort", 2, 20);

    // Reset in the middle of a run.
    begin_run(16'h0100, 10);
    repeat (4) cycle();
    reset_n = 1'b0;
    #1;
    check("rst_mid_ctrl", 64'({mem_chipselect, out_valid, out_last, done, busy}), 64'd0);
    check("rst_mid_addr", 64'(mem_address), 64'd0);
    cycle();
    cycle();
    reset_n = 1'b1;
    cs_hold = cs_total;
    k       = done_total;
    repeat (6) cycle();
    check("rst_mid_no_reads", 64'(cs_total - cs_hold), 64'd0);
    check("rst_mid_no_done",  64'(done_total - k), 64'd0);
    begin_run(16'h0020, 2);
    finish_run("post_reset", 2, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
